branch_fetch_unit: RTL and testbench

//  PC-generation/fetch stage directly upstream of the quick branch cache (BTB).

---
 rtl/branch_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_branch_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_fetch_unit.sv
// PC-generation / fetch stage feeding the BTB, with an in-flight prediction FIFO and
// mispredict redirect. Define BFU_STATS_EN to build the saturating branch/mispredict counters.
module branch_fetch_unit #(
    parameter int unsigned PC_WIDTH = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                fetch_valid,
    input  logic                btb_hit,
    input  logic [PC_WIDTH-1:0] btb_target,
    input  logic                resolve_valid,
    input  logic                resolve_is_branch,
    input  logic                resolve_taken,
    input  logic [PC_WIDTH-1:0] resolve_target,
    output logic                flush,
    output logic                btb_we,
    output logic [PC_WIDTH-1:0] btb_update_pc,
    output logic [PC_WIDTH-1:0] btb_store_pc,
    output logic                resolve_underflow,
    output logic [15:0]         stat_branches,
    output logic [15:0]         stat_mispredicts
);

    localparam int unsigned PTR_W  = $clog2(QDEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAT_W = 16;

    // Prediction-tracking FIFO storage
    logic [PC_WIDTH-1:0] q_pc  [QDEPTH];
    logic [PC_WIDTH-1:0] q_tgt [QDEPTH];
    logic [QDEPTH-1:0]   q_hit;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] head_pc;
    logic [PC_WIDTH-1:0] head_tgt;
    logic                head_hit;
    logic [PC_WIDTH-1:0] head_seq;
    logic [PC_WIDTH-1:0] pred_next;
    logic [PC_WIDTH-1:0] act_next;
    logic                actual_taken;
    logic                mispredict;
    logic                btb_write;
    logic [PC_WIDTH-1:0] issue_next;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(QDEPTH));
    assign fetch_valid = !fifo_full && !stall;
    assign push        = fetch_valid;
    assign pop         = resolve_valid && !fifo_empty;
    assign flush       = pop && mispredict;

    // Resolve-side compare of the oldest prediction against the actual outcome
    always_comb begin
        head_pc      = q_pc[rd_ptr];
        head_tgt     = q_tgt[rd_ptr];
        head_hit     = q_hit[rd_ptr];
        head_seq     = head_pc + PC_WIDTH'(1);
        actual_taken = resolve_is_branch && resolve_taken;
        pred_next    = head_hit ? head_tgt : head_seq;
        act_next     = actual_taken ? resolve_target : head_seq;
        mispredict   = (pred_next != act_next);
        btb_write    = pop && actual_taken && (!head_hit || (head_tgt != resolve_target));
        issue_next   = btb_hit ? btb_target : (fetch_pc + PC_WIDTH'(1));
    end

    // FIFO payload; stale entries are harmless because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= fetch_pc;
            q_tgt[wr_ptr] <= btb_target;
            q_hit[wr_ptr] <= btb_hit;
        end
    end

    // PC register and FIFO control; a flush discards the same-cycle push as well
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= PC_WIDTH'(RESET_PC);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            fetch_pc <= act_next;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= issue_next;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // BTB training pulse; addresses keep their last written value between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_we            <= 1'b0;
            btb_update_pc     <= '0;
            btb_store_pc      <= '0;
            resolve_underflow <= 1'b0;
        end else begin
            btb_we <= btb_write;
            if (btb_write) begin
                btb_update_pc <= head_pc;
                btb_store_pc  <= resolve_target;
            end
            if (resolve_valid && fifo_empty) begin
                resolve_underflow <= 1'b1;
            end
        end
    end

`ifdef BFU_STATS_EN
    logic [STAT_W-1:0] branches_q;
    logic [STAT_W-1:0] mispredicts_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (pop && resolve_is_branch && (branches_q != '1)) begin
                branches_q <= branches_q + STAT_W'(1);
            end
            if (flush && (mispredicts_q != '1)) begin
                mispredicts_q <= mispredicts_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Randomized bench for branch_fetch_unit against a queue-based reference model.
module tb_branch_fetch_unit;

    localparam int unsigned PCW = 10;
    localparam int unsigned QD  = 4;

    typedef struct {
        logic [PCW-1:0] pc;
        logic           hit;
        logic [PCW-1:0] tgt;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           stall;
    logic [PCW-1:0] fetch_pc;
    logic           fetch_valid;
    logic           btb_hit;
    logic [PCW-1:0] btb_target;
    logic           resolve_valid;
    logic           resolve_is_branch;
    logic           resolve_taken;
    logic [PCW-1:0] resolve_target;
    logic           flush;
    logic           btb_we;
    logic [PCW-1:0] btb_update_pc;
    logic [PCW-1:0] btb_store_pc;
    logic           resolve_underflow;
    logic [15:0]    stat_branches;
    logic [15:0]    stat_mispredicts;

    branch_fetch_unit #(.PC_WIDTH(PCW), .RESET_PC(0), .QDEPTH(QD)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid),
        .btb_hit           (btb_hit),
        .btb_target        (btb_target),
        .resolve_valid     (resolve_valid),
        .resolve_is_branch (resolve_is_branch),
        .resolve_taken     (resolve_taken),
        .resolve_target    (resolve_target),
        .flush             (flush),
        .btb_we            (btb_we),
        .btb_update_pc     (btb_update_pc),
        .btb_store_pc      (btb_store_pc),
        .resolve_underflow (resolve_underflow),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    rec_t           mq[$];
    logic [PCW-1:0] m_pc;
    logic           m_we;
    logic [PCW-1:0] m_upd;
    logic [PCW-1:0] m_store;
    logic           m_uf;
    int             m_br;
    int             m_mis;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = '0; m_we = 1'b0; m_upd = '0; m_store = '0; m_uf = 1'b0;
        m_br = 0; m_mis = 0;
    endtask

    // One cycle: drive at negedge, check outputs, then advance the model past the next posedge
    task automatic step(input logic rst, input logic stl, input logic hit, input logic [PCW-1:0] tgt,
                        input logic rv, input logic rb, input logic rt, input logic [PCW-1:0] rtg);
        logic           fv, pop, fl, wr;
        logic [PCW-1:0] act;
        rec_t           rec;
        @(negedge clk);
        rst_n = rst; stall = stl; btb_hit = hit; btb_target = tgt;
        resolve_valid = rv; resolve_is_branch = rb; resolve_taken = rt; resolve_target = rtg;
        #1;
        fv  = (mq.size() < QD) && !stl;
        pop = rv && (mq.size() > 0);
        fl  = 1'b0; wr = 1'b0; act = '0;
        if (pop) begin
            rec = mq[0];
            act = (rb && rt) ? rtg : rec.pc + 1'b1;
            fl  = ((rec.hit ? rec.tgt : rec.pc + 1'b1) != act);
            wr  = rb && rt && (!rec.hit || rec.tgt != rtg);
        end
        check_eq("fetch_pc", 32'(fetch_pc), 32'(m_pc));
        check_eq("fetch_valid", 32'(fetch_valid), 32'(fv));
        check_eq("flush", 32'(flush), 32'(fl));
        check_eq("btb_we", 32'(btb_we), 32'(m_we));
        check_eq("btb_update_pc", 32'(btb_update_pc), 32'(m_upd));
        check_eq("btb_store_pc", 32'(btb_store_pc), 32'(m_store));
        check_eq("resolve_underflow", 32'(resolve_underflow), 32'(m_uf));
`ifdef BFU_STATS_EN
        check_eq("stat_branches", 32'(stat_branches), 32'(m_br > 65535 ? 65535 : m_br));
        check_eq("stat_mispredicts", 32'(stat_mispredicts), 32'(m_mis > 65535 ? 65535 : m_mis));
`else
        check_eq("stat_branches", 32'(stat_branches), 32'd0);
        check_eq("stat_mispredicts", 32'(stat_mispredicts), 32'd0);
`endif
        if (!rst) begin
            model_reset();
        end else begin
            m_we = wr;
            if (wr) begin
                m_upd = rec.pc; m_store = rtg;
            end
            if (rv && mq.size() == 0) m_uf = 1'b1;
            if (pop && rb) m_br++;
            if (fl) m_mis++;
            if (fl) begin
                m_pc = act;
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (fv) begin
                    mq.push_back('{pc: m_pc, hit: hit, tgt: tgt});
                    m_pc = hit ? tgt : m_pc + 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input logic hit, input logic [PCW-1:0] tgt);
        step(1'b1, 1'b0, hit, tgt, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic           s, h, rv, rb, rt;
        logic [PCW-1:0] t, rtg;
        rec_t           hd;
        rst_n = 1'b0; stall = 1'b0; btb_hit = 1'b0; btb_target = '0;
        resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Sequential fill to full, then one non-branch resolve frees a slot
        repeat (5) idle(1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        idle(1'b0, '0);
        // Underflow stickiness after draining
        repeat (4) step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 10'h055);
        idle(1'b0, '0);

        // Mid-run reset with BTB write pending, then wrap-around and mispredict scenarios
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 10'h100);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        idle(1'b1, 10'h3FF);
        idle(1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 10'h010, 1'b1, 1'b1, 1'b1, 10'h3FF);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        idle(1'b0, '0);
        idle(1'b0, '0);

        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom % 5) == 0;
            h   = ($urandom % 3) == 0;
            t   = ($urandom % 4 == 0) ? 10'h3FE : PCW'($urandom_range(0, 63));
            rv  = ($urandom % 2) == 0;
            rb  = $urandom % 2;
            rt  = $urandom % 2;
            rtg = PCW'($urandom_range(0, 63));
            if (mq.size() > 0 && ($urandom % 3) != 0) begin
                hd = mq[0];
                if (hd.hit) begin
                    rb = 1'b1; rt = 1'b1; rtg = hd.tgt;
                end else begin
                    rt = 1'b0;
                end
            end
            step(($urandom % 250) != 0, s, h, t, rv, rb, rt, rtg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
